// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared CPU constants and helpers for the IF-stage PC unit
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INCR       = 32'd4;
  localparam logic [31:0] LINK_OFFSET   = 32'd8;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JIMM   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_sel_e;

  // Sign-extended word offset of a branch immediate, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// rtl/fetch_pc_unit_npc_calc.sv - next-PC target computation and priority mux
module fetch_pc_unit_npc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] if_pc_i,
  input  logic [31:0] id_pc_i,
  input  logic        branch_i,
  input  logic        jump_imm_i,
  input  logic        jump_reg_i,
  input  logic [15:0] id_imm16_i,
  input  logic [25:0] id_instr_index_i,
  input  logic [31:0] id_rs_val_i,
  output logic [31:0] npc_o
);

  logic [31:0] id_pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  npc_sel_e    sel;

  // Targets are relative to the delay-slot address (id_pc + 4); arithmetic wraps.
  always_comb begin
    id_pc_plus4 = id_pc_i + PC_INCR;
    br_tgt      = id_pc_plus4 + branch_offset(id_imm16_i);
    j_tgt       = {id_pc_plus4[31:28], id_instr_index_i, 2'b00};
  end

  // Priority: register jump over immediate jump over branch over sequential.
  always_comb begin
    sel = NPC_SEQ;
    if (jump_reg_i)      sel = NPC_JREG;
    else if (jump_imm_i) sel = NPC_JIMM;
    else if (branch_i)   sel = NPC_BRANCH;
  end

  // Select the raw next PC; alignment is handled by the caller.
  always_comb begin
    npc_o = if_pc_i + PC_INCR;
    case (sel)
      NPC_JREG:   npc_o = id_rs_val_i;
      NPC_JIMM:   npc_o = j_tgt;
      NPC_BRANCH: npc_o = br_tgt;
      default:    npc_o = if_pc_i + PC_INCR;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC register and IF/ID pipeline register; optional checks under FETCH_CHECK_EN
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump_imm,
  input  logic        jump_reg,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_instr_index,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] im_instr,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        fetch_err
);

  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] npc_raw;

  fetch_pc_unit_npc_calc u_npc_calc (
    .if_pc_i          (if_pc_q),
    .id_pc_i          (id_pc_q),
    .branch_i         (branch),
    .jump_imm_i       (jump_imm),
    .jump_reg_i       (jump_reg),
    .id_imm16_i       (id_imm16),
    .id_instr_index_i (id_instr_index),
    .id_rs_val_i      (id_rs_val),
    .npc_o            (npc_raw)
  );

  // Advance PC and IF/ID together unless the hazard unit stalls; no delay-slot flush.
  always_comb begin
    if_pc_d    = if_pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (!stall) begin
      if_pc_d    = npc_raw & 32'hFFFF_FFFC;
      id_pc_d    = if_pc_q;
      id_instr_d = im_instr;
      id_valid_d = 1'b1;
    end
  end

  // PC and IF/ID state; reset discards IF/ID contents immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_pc_q    <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      if_pc_q    <= if_pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef FETCH_CHECK_EN
  logic err_q, err_d;
  logic multi_sel;
  logic misaligned;

  // Flag misaligned targets or conflicting selects on an advancing edge; sticky.
  always_comb begin
    multi_sel  = (jump_reg & jump_imm) | (jump_reg & branch) | (jump_imm & branch);
    misaligned = (npc_raw[1:0] != 2'b00);
    err_d      = err_q;
    if (!stall && (multi_sel || misaligned)) err_d = 1'b1;
  end

  // Sticky fault register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign if_pc    = if_pc_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_valid = id_valid_q;
  assign id_pc8   = id_pc_q + LINK_OFFSET;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

`ifdef FETCH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch, jump_imm, jump_reg;
  logic [15:0] id_imm16;
  logic [25:0] id_instr_index;
  logic [31:0] id_rs_val, im_instr;
  logic [31:0] if_pc, id_pc, id_instr, id_pc8;
  logic        id_valid, fetch_err;

  int tests = 0;
  int fails = 0;

  fetch_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch(branch),
    .jump_imm(jump_imm), .jump_reg(jump_reg), .id_imm16(id_imm16),
    .id_instr_index(id_instr_index), .id_rs_val(id_rs_val), .im_instr(im_instr),
    .if_pc(if_pc), .id_pc(id_pc), .id_instr(id_instr), .id_pc8(id_pc8),
    .id_valid(id_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, branch, jimm, jreg;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs, instr;
    logic [31:0] e_if_pc, e_id_pc, e_id_instr;
    logic        e_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic ji, input logic jr,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] rs, input logic [31:0] ins);
    stall = s; branch = b; jump_imm = ji; jump_reg = jr;
    id_imm16 = imm; id_instr_index = idx; id_rs_val = rs; im_instr = ins;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".if_pc"},    if_pc,    32'h0000_3000);
    chk({tag, ".id_pc"},    id_pc,    32'h0);
    chk({tag, ".id_instr"}, id_instr, 32'h0);
    chk({tag, ".id_valid"}, {31'b0, id_valid},  32'h0);
    chk({tag, ".id_pc8"},   id_pc8,   32'h8);
    chk({tag, ".fetch_err"},{31'b0, fetch_err}, 32'h0);
  endtask

  // Reference model state
  logic [31:0] m_pc, m_idpc, m_idinstr;
  logic        m_valid, m_err;

  task automatic model_reset();
    m_pc = 32'h3000; m_idpc = 0; m_idinstr = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    int nsel;
    if (stall) return;
    nsel = int'(branch) + int'(jump_imm) + int'(jump_reg);
    if (jump_reg)      tgt = id_rs_val;
    else if (jump_imm) tgt = ((m_idpc + 4) & 32'hF000_0000) | (32'(id_instr_index) * 4);
    else if (branch)   tgt = m_idpc + 4 + 32'($signed(id_imm16)) * 4;
    else               tgt = m_pc + 4;
    if (CHK && (nsel > 1 || tgt % 4 != 0)) m_err = 1'b1;
    m_idpc = m_pc; m_idinstr = im_instr; m_valid = 1'b1;
    m_pc = tgt - (tgt % 4);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".if_pc"},    if_pc,    m_pc);
    chk({tag, ".id_pc"},    id_pc,    m_idpc);
    chk({tag, ".id_instr"}, id_instr, m_idinstr);
    chk({tag, ".id_valid"}, {31'b0, id_valid},  {31'b0, m_valid});
    chk({tag, ".id_pc8"},   id_pc8,   m_idpc + 8);
    chk({tag, ".fetch_err"},{31'b0, fetch_err}, {31'b0, m_err});
  endtask

  initial begin
    //          stall br ji jr  imm        idx           rs            instr          if_pc        id_pc        id_instr     err
    vecs[0]  = '{0,0,0,0, 16'h0000, 26'h0,     32'h0,        32'h1111_1111, 32'h3004, 32'h3000, 32'h1111_1111, 0};
    vecs[1]  = '{0,0,0,0, 16'h0000, 26'h0,     32'h0,        32'h1111_1111, 32'h3008, 32'h3004, 32'h1111_1111, 0};
    vecs[2]  = '{0,1,0,0, 16'hFFFF, 26'h0,     32'h0,        32'h2222_2222, 32'h3004, 32'h3008, 32'h2222_2222, 0};
    vecs[3]  = '{0,0,0,0, 16'h0000, 26'h0,     32'h0,        32'h3333_3333, 32'h3008, 32'h3004, 32'h3333_3333, 0};
    vecs[4]  = '{0,0,1,0, 16'h0000, 26'h0C40,  32'h0,        32'h4444_4444, 32'h3100, 32'h3008, 32'h4444_4444, 0};
    vecs[5]  = '{0,0,1,1, 16'h0000, 26'h0C40,  32'h3200,     32'h5555_5555, 32'h3200, 32'h3100, 32'h5555_5555, CHK};
    vecs[6]  = '{1,1,0,0, 16'h0010, 26'h0,     32'h0,        32'h6666_6666, 32'h3200, 32'h3100, 32'h5555_5555, CHK};
    vecs[7]  = '{1,1,0,0, 16'h0010, 26'h0,     32'h0,        32'h6666_6666, 32'h3200, 32'h3100, 32'h5555_5555, CHK};
    vecs[8]  = '{1,1,0,0, 16'h0010, 26'h0,     32'h0,        32'h6666_6666, 32'h3200, 32'h3100, 32'h5555_5555, CHK};
    vecs[9]  = '{0,1,0,0, 16'h0010, 26'h0,     32'h0,        32'h6666_6666, 32'h3144, 32'h3200, 32'h6666_6666, CHK};
    vecs[10] = '{0,0,0,1, 16'h0000, 26'h0,     32'h3002,     32'h7777_7777, 32'h3000, 32'h3144, 32'h7777_7777, CHK};
    vecs[11] = '{0,0,0,0, 16'h0000, 26'h0,     32'h0,        32'h8888_8888, 32'h3004, 32'h3000, 32'h8888_8888, CHK};

    drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].stall, vecs[i].branch, vecs[i].jimm, vecs[i].jreg,
            vecs[i].imm, vecs[i].idx, vecs[i].rs, vecs[i].instr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.if_pc", i),    if_pc,    vecs[i].e_if_pc);
      chk($sformatf("vec%0d.id_pc", i),    id_pc,    vecs[i].e_id_pc);
      chk($sformatf("vec%0d.id_instr", i), id_instr, vecs[i].e_id_instr);
      chk($sformatf("vec%0d.id_valid", i), {31'b0, id_valid}, 32'h1);
      chk($sformatf("vec%0d.id_pc8", i),   id_pc8,   vecs[i].e_id_pc + 32'd8);
      chk($sformatf("vec%0d.fetch_err", i),{31'b0, fetch_err}, {31'b0, vecs[i].e_err});
    end

    // Async reset between edges: values return without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Wrap-around: jr to the last word, then sequential wraps to 0
    drive(0, 0, 0, 1, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hABCD_0001);
    model_step();
    @(posedge clk); #1;
    chk_model("wrap_a");
    drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'hABCD_0002);
    model_step();
    @(posedge clk); #1;
    chk_model("wrap_b");
    chk("wrap_zero", if_pc, 32'h0);

    // Branch target wrapping below zero from id_pc near the top
    drive(0, 1, 0, 0, 16'h8000, 26'h0, 32'h0, 32'hABCD_0003);
    model_step();
    @(posedge clk); #1;
    chk_model("br_neg");

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      drive(r[2:0] == 3'd0, r[3] & r[4], r[5] & r[6] & r[7], r[8] & r[9] & r[10],
            16'($urandom), 26'($urandom),
            (r[11] ? {$urandom} : ({$urandom} & 32'hFFFF_FFFC)), $urandom);
      if (r[31:28] == 4'h0) begin
        // occasional reset; checks reset values directly
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_model($sformatf("rnd%0d.rst", n));
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        model_step();
        @(posedge clk); #1;
        chk_model($sformatf("rnd%0d", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
